// File: rtl/ctrl_issue_sched.sv
// ctrl_issue_sched: 4-stage control-word issue scheduler with stall, RAW-hazard bubbles and branch flush.
// Optional macro HZ_STALL_CNT_EN adds a saturating hazard-stall counter output hz_cnt.
`default_nettype none

module ctrl_issue_sched #(
  parameter int WIDTH     = 8,
  parameter int RAW       = 3,
  parameter int HZ_DEPTH  = 3,
  parameter int FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_ctrl,
  input  logic             in_we,
  input  logic [RAW-1:0]   in_rd,
  input  logic [RAW-1:0]   in_rs1,
  input  logic [RAW-1:0]   in_rs2,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  output logic             v4,
`ifdef HZ_STALL_CNT_EN
  output logic [15:0]      hz_cnt,
`endif
  output logic             hz_stall
);

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC);

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] ctrl_q [4];
  logic [RAW-1:0]   rd_q   [4];
  logic [3:0]       vld_q;
  logic [3:0]       we_q;
  logic             hazard;
  logic             transfer;

  // Only the youngest HZ_DEPTH stages can still be ahead of a consumer's register read.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < HZ_DEPTH; k++) begin
      if (vld_q[k] && we_q[k] && (rd_q[k] != '0) &&
          ((rd_q[k] == in_rs1) || (rd_q[k] == in_rs2)))
        hazard = 1'b1;
    end
    hazard = hazard && in_valid && (state == RUN);
  end

  assign in_ready = (state == RUN) && !stall && !flush && !hazard;
  assign transfer = in_valid && in_ready;
  assign hz_stall = hazard && !stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
      vld_q <= '0;
      we_q  <= '0;
      for (int k = 0; k < 4; k++) begin
        ctrl_q[k] <= '0;
        rd_q[k]   <= '0;
      end
    end else if (flush) begin
      // The oldest survivor still retires; everything younger is killed.
      ctrl_q[3] <= ctrl_q[2];
      rd_q[3]   <= rd_q[2];
      vld_q     <= {vld_q[2], 3'b000};
      we_q      <= {we_q[2], 3'b000};
      for (int k = 0; k < 3; k++) begin
        ctrl_q[k] <= '0;
        rd_q[k]   <= '0;
      end
      state <= FLUSH;
      cnt   <= FLUSH_LOAD;
    end else if (!stall) begin
      for (int k = 1; k < 4; k++) begin
        ctrl_q[k] <= ctrl_q[k-1];
        rd_q[k]   <= rd_q[k-1];
      end
      ctrl_q[0] <= transfer ? in_ctrl : '0;
      rd_q[0]   <= transfer ? in_rd : '0;
      vld_q     <= {vld_q[2:0], transfer};
      we_q      <= {we_q[2:0], transfer && in_we};
      if (state == FLUSH) begin
        if (cnt <= 4'd1) begin
          state <= RUN;
          cnt   <= '0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

`ifdef HZ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hz_cnt <= '0;
    else if (hz_stall && (hz_cnt != 16'hFFFF))
      hz_cnt <= hz_cnt + 16'd1;
  end
`endif

  assign out1 = ctrl_q[0];
  assign out2 = ctrl_q[1];
  assign out3 = ctrl_q[2];
  assign out4 = ctrl_q[3];
  assign v1   = vld_q[0];
  assign v2   = vld_q[1];
  assign v3   = vld_q[2];
  assign v4   = vld_q[3];

endmodule

`default_nettype wire

// File: doc/ctrl_issue_sched.md
Name: ctrl_issue_sched

Overview:
Issue scheduler for the processor's 4-stage control-word pipeline. Accepts decoded control words over a valid/ready handshake and inserts them into stage 1. Shifts stages 1->4 each cycle. Handles external stall, read-after-write hazard bubbles and branch flush, so downstream execute/mem/writeback logic sees a per-stage control word plus a valid bit.

Parameters:
WIDTH, 8, control word width
RAW, 3, register address width (register 0 never causes a hazard)
HZ_DEPTH, 3, number of stages (1..HZ_DEPTH) checked for RAW hazards, legal 1-4
FLUSH_CYC, 2, refill bubbles after a flush, legal 1-15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode offers a control word
in_ready  out  1  scheduler accepts this cycle (transfer = in_valid & in_ready)
in_ctrl  in  WIDTH  control word
in_we  in  1  word writes register in_rd
in_rd  in  RAW  destination register
in_rs1  in  RAW  source register 1
in_rs2  in  RAW  source register 2
stall  in  1  external hold (memory busy)
flush  in  1  one-cycle branch-mispredict kill
out1..out4  out  WIDTH each  stage control words
v1..v4  out  1 each  stage valid bits
hz_stall  out  1  RAW bubble inserted this cycle

Behaviour:
- Reset (async, rst_n=0): out1-4=0, v1-4=0, internal we/rd per stage=0, state=RUN, flush counter=0, hz_stall=0.
- Control state machine:
  - RUN to FLUSH on flush.
  - FLUSH counts FLUSH_CYC cycles, then returns to RUN.
  - A flush while in FLUSH reloads the counter to FLUSH_CYC.
- Priority per cycle: flush > stall > hazard > issue/bubble.
- hazard (combinational) =
  - in_valid, and
  - state==RUN, and
  - some stage k<=HZ_DEPTH has vk=1, stage we=1, stage rd!=0, and stage rd equal to in_rs1 or in_rs2.
- in_ready = (state==RUN) & !stall & !flush & !hazard. It is combinational and does not depend on in_valid.
- Normal shift (no flush, no stall): stage4<=stage3, stage3<=stage2, stage2<=stage1. Stage1 loads the new word on transfer, otherwise a bubble.
- Bubble = ctrl word 0, valid 0, we 0.
- Latency: a word accepted in cycle N appears on out1/v1 at N+1 and on out4 at N+4 when there are no stalls.
- Stall: all four stages hold their ctrl, valid, we and rd; no transfer occurs. While state==FLUSH, the flush counter also holds.
- Hazard (no stall): stage1 <= bubble, stages 2-4 shift, hz_stall=1, and the word stays offered. Forward progress is guaranteed because the producer drains within HZ_DEPTH cycles.
- Flush (dominates stall): v1, v2 and v3 are cleared to bubbles; stage4 <= stage3's old contents, so the oldest survivor completes. No transfer occurs in the flush cycle. Counter := FLUSH_CYC.
- In FLUSH: stages shift with bubbles into stage1. in_ready=0 and hz_stall=0.
- hz_stall is registered-free (combinational): hazard & !stall & !flush.
- in_valid dropping while not ready is legal (decode may retract on its own flush).

Optional Feature:
- Macro HZ_STALL_CNT_EN adds output hz_cnt[15:0]:
  - Increments on every cycle with hz_stall=1 and saturates at 16'hFFFF.
  - Reset value is 0; flush does not clear it.
- Without the macro, the port and counter do not exist.

Test Plan:
- Reset then independent words A=8'h11, B=8'h22, C=8'h33, D=8'h44 on consecutive cycles, in_valid=1, no hazards -> out1..out4 = 44,33,22,11 with v1-4=1 four cycles after A is accepted; in_ready=1 throughout.
- Word writing r3 then word reading rs1=r3, HZ_DEPTH=3 -> hz_stall=1 for 3 cycles, 3 bubbles enter stage1, and the consumer is accepted on the 4th cycle. With HZ_STALL_CNT_EN, hz_cnt=3.
- Hazard on rd=0 (we=1, rd=0, consumer rs2=0) -> no stall; consumer accepted the next cycle.
- Pipeline full, stall=1 for 5 cycles -> out1-4 and v1-4 unchanged, in_ready=0; shifting resumes the cycle after stall falls.
- Flush asserted together with stall while stages hold A..D (A in stage4, D in stage1), FLUSH_CYC=2:
  - Next cycle v1=v2=v3=0 and out4=B.
  - in_ready=0 for 3 cycles (flush cycle plus 2), then 1.
- rst_n pulled low mid-FLUSH with full valid stages -> all outputs 0 immediately (asynchronous); after release, state=RUN and in_ready=1 on the first clock.
